// File: rtl/score_leaderboard_pkg.sv
// Shared types for the leaderboard: controller state encoding and width helpers
// used by every file that sizes player ids or leaderboard ranks.
package score_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_COMPARE,
    ST_INSERT,
    ST_REPORT
  } state_t;

  function automatic int pid_w(input int num_players);
    return (num_players <= 2) ? 1 : $clog2(num_players);
  endfunction

  function automatic int rank_w(input int rank_depth);
    return $clog2(rank_depth + 1);
  endfunction

endpackage

// File: rtl/score_leaderboard_if.sv
// Submission handshake and result pulse between the game core (master) and the
// leaderboard (slave).
interface score_leaderboard_if #(
  parameter int PID_W   = 2,
  parameter int SCORE_W = 15,
  parameter int RANK_W  = 2
);
  logic               sub_valid;
  logic               sub_ready;
  logic [PID_W-1:0]   sub_pid;
  logic [SCORE_W-1:0] sub_score;
  logic               res_valid;
  logic               res_personal;
  logic               res_global;
  logic [RANK_W-1:0]  res_rank;

  modport master (
    output sub_valid, sub_pid, sub_score,
    input  sub_ready, res_valid, res_personal, res_global, res_rank
  );

  modport slave (
    input  sub_valid, sub_pid, sub_score,
    output sub_ready, res_valid, res_personal, res_global, res_rank
  );
endinterface

// File: rtl/score_leaderboard_rank_insert.sv
// Combinational leaderboard insert: finds the first slot a score strictly beats
// (or an empty slot) and builds the shifted board image; a zero score never ranks.
module rank_insert
  import score_pkg::*;
#(
  parameter int NUM_PLAYERS = 4,
  parameter int SCORE_W     = 15,
  parameter int RANK_DEPTH  = 3,
  localparam int PID_W      = pid_w(NUM_PLAYERS),
  localparam int RANK_W     = rank_w(RANK_DEPTH),
  localparam int ENTRY_W    = 1 + PID_W + SCORE_W
) (
  input  logic [RANK_DEPTH-1:0][ENTRY_W-1:0] i_board,
  input  logic [PID_W-1:0]                   i_pid,
  input  logic [SCORE_W-1:0]                 i_score,
  output logic [RANK_W-1:0]                  o_pos,
  output logic [RANK_DEPTH-1:0][ENTRY_W-1:0] o_board
);

  typedef struct packed {
    logic               valid;
    logic [PID_W-1:0]   pid;
    logic [SCORE_W-1:0] score;
  } entry_t;

  entry_t [RANK_DEPTH-1:0] w_in;
  entry_t [RANK_DEPTH-1:0] w_out;
  logic                    w_hit;

  assign w_in    = i_board;
  assign o_board = w_out;

  always_comb begin
    w_hit = 1'b0;
    o_pos = RANK_W'(RANK_DEPTH);
    for (int i = 0; i < RANK_DEPTH; i++) begin
      if (!w_hit && i_score != '0 && (!w_in[i].valid || i_score > w_in[i].score)) begin
        w_hit = 1'b1;
        o_pos = RANK_W'(i);
      end
    end

    // Entries below the insertion point slide down one slot; the last one falls off.
    w_out = w_in;
    for (int i = 0; i < RANK_DEPTH; i++) begin
      if (w_hit && i == int'(o_pos)) begin
        w_out[i] = '{valid: 1'b1, pid: i_pid, score: i_score};
      end else if (w_hit && i > int'(o_pos)) begin
        w_out[i] = w_in[(i == 0) ? 0 : i - 1];
      end
    end
  end

endmodule

// File: rtl/score_leaderboard.sv
// Per-player best score and top-K leaderboard; result pulse 4 cycles after accept.
// sub_ready is high only in IDLE, so one submission is taken every 5 cycles at most.
module score_leaderboard
  import score_pkg::*;
#(
  parameter int NUM_PLAYERS = 4,
  parameter int SCORE_W     = 15,
  parameter int RANK_DEPTH  = 3,
  localparam int PID_W      = pid_w(NUM_PLAYERS),
  localparam int RANK_W     = rank_w(RANK_DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  score_leaderboard_if.slave  bus,
  input  logic                clr_all,
  input  logic [PID_W-1:0]    qry_pid,
  output logic [SCORE_W-1:0]  qry_best,
  output logic [SCORE_W-1:0]  top_score,
  output logic [PID_W-1:0]    top_pid
);

  typedef struct packed {
    logic               valid;
    logic [PID_W-1:0]   pid;
    logic [SCORE_W-1:0] score;
  } entry_t;

  state_t                  r_state;
  logic [PID_W-1:0]        r_pid;
  logic [SCORE_W-1:0]      r_score;
  logic                    r_pid_ok;
  logic [SCORE_W-1:0]      r_best [NUM_PLAYERS];
  logic [SCORE_W-1:0]      r_best_cur;
  entry_t [RANK_DEPTH-1:0] r_board;
  logic [RANK_W-1:0]       r_pos;
  logic                    r_personal;
  logic                    r_global;
  logic                    r_res_valid;
  logic                    r_res_personal;
  logic                    r_res_global;
  logic [RANK_W-1:0]       r_res_rank;
  logic [SCORE_W-1:0]      r_qry_best;

  entry_t [RANK_DEPTH-1:0] w_next_board;
  logic [RANK_W-1:0]       w_pos;
  logic [SCORE_W-1:0]      w_eff_score;
  logic                    w_sub_pid_ok;
  logic                    w_qry_ok;

  assign w_sub_pid_ok = int'(bus.sub_pid) < NUM_PLAYERS;
  assign w_qry_ok     = int'(qry_pid) < NUM_PLAYERS;
  // An out-of-range player ranks like a zero score: never inserted.
  assign w_eff_score  = r_pid_ok ? r_score : '0;

  rank_insert #(
    .NUM_PLAYERS (NUM_PLAYERS),
    .SCORE_W     (SCORE_W),
    .RANK_DEPTH  (RANK_DEPTH)
  ) u_rank_insert (
    .i_board (r_board),
    .i_pid   (r_pid),
    .i_score (w_eff_score),
    .o_pos   (w_pos),
    .o_board (w_next_board)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_pid          <= '0;
      r_score        <= '0;
      r_pid_ok       <= 1'b0;
      r_best         <= '{default: '0};
      r_best_cur     <= '0;
      r_board        <= '0;
      r_pos          <= RANK_W'(RANK_DEPTH);
      r_personal     <= 1'b0;
      r_global       <= 1'b0;
      r_res_valid    <= 1'b0;
      r_res_personal <= 1'b0;
      r_res_global   <= 1'b0;
      r_res_rank     <= RANK_W'(RANK_DEPTH);
      r_qry_best     <= '0;
    end else begin
      r_res_valid <= 1'b0;
      r_qry_best  <= w_qry_ok ? r_best[qry_pid] : '0;
      case (r_state)
        ST_IDLE: begin
          if (bus.sub_valid) begin
            r_pid    <= bus.sub_pid;
            r_score  <= bus.sub_score;
            r_pid_ok <= w_sub_pid_ok;
            r_state  <= ST_LOOKUP;
          end else if (clr_all) begin
            r_best  <= '{default: '0};
            r_board <= '0;
          end
        end
        ST_LOOKUP: begin
          r_best_cur <= r_pid_ok ? r_best[r_pid] : '0;
          r_pos      <= w_pos;
          r_state    <= ST_COMPARE;
        end
        ST_COMPARE: begin
          r_personal <= r_pid_ok && (r_score > r_best_cur);
          if (r_pid_ok && r_score > r_best_cur) begin
            r_best[r_pid] <= r_score;
          end
          r_global <= (r_pos == '0);
          r_state  <= ST_INSERT;
        end
        ST_INSERT: begin
          // The board has not moved since LOOKUP, so the insert image is still valid.
          if (r_pos != RANK_W'(RANK_DEPTH)) begin
            r_board <= w_next_board;
          end
          r_res_valid    <= 1'b1;
          r_res_personal <= r_personal;
          r_res_global   <= r_global;
          r_res_rank     <= r_pos;
          r_state        <= ST_REPORT;
        end
        ST_REPORT: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.sub_ready    = (r_state == ST_IDLE);
  assign bus.res_valid    = r_res_valid;
  assign bus.res_personal = r_res_personal;
  assign bus.res_global   = r_res_global;
  assign bus.res_rank     = r_res_rank;
  assign qry_best         = r_qry_best;
  assign top_score        = r_board[0].valid ? r_board[0].score : '0;
  assign top_pid          = r_board[0].valid ? r_board[0].pid : '0;

endmodule
